// File: rtl/acc_xfer_ctrl.sv
// Register-transfer sequencer for the accumulator load/dump bus: one command at a time,
// source drive for a settle cycle, then source plus destination load, then a done pulse.
module acc_xfer_ctrl #(
   parameter int NREG     = 4,
   parameter int REG_W    = 2,
   parameter int ALU_OP_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [REG_W-1:0]    cmd_reg,
   input  logic [ALU_OP_W-1:0] cmd_alu,
   output logic                LoadAcc,
   output logic                DumpAcc,
   output logic [NREG-1:0]     LoadReg,
   output logic [NREG-1:0]     DumpReg,
   output logic                alu_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                done,
   output logic                err
);

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_R2A = 2'b01;
   localparam logic [1:0] OP_A2R = 2'b10;
   localparam logic [1:0] OP_ALU = 2'b11;

   state_t                state;
   state_t                next_state;
   logic [1:0]            op_q;
   logic [REG_W-1:0]      reg_q;
   logic [ALU_OP_W-1:0]   alu_q;
   logic                  err_q;
   logic                  accept;
   logic                  bad_index;
   logic [NREG-1:0]       reg_onehot;

   assign accept     = (state == IDLE) && cmd_valid;
   // NOP never touches a register, so its index field is not range-checked.
   assign bad_index  = (cmd_op != OP_NOP) && ({1'b0, cmd_reg} >= (REG_W+1)'(NREG));
   assign reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << reg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q  <= OP_NOP;
         reg_q <= '0;
         alu_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         op_q  <= bad_index ? OP_NOP : cmd_op;
         reg_q <= cmd_reg;
         alu_q <= cmd_alu;
         err_q <= bad_index;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = ((cmd_op == OP_NOP) || bad_index) ? DONE : DRIVE;
            end
         end
         DRIVE:   next_state = LATCH;
         LATCH:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes come only from the state and the latched command, never from cmd_* directly.
   always_comb begin
      cmd_ready = 1'b0;
      LoadAcc   = 1'b0;
      DumpAcc   = 1'b0;
      LoadReg   = '0;
      DumpReg   = '0;
      alu_sel   = 1'b0;
      alu_op    = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: cmd_ready = 1'b1;
         DRIVE, LATCH: begin
            case (op_q)
               OP_R2A: begin
                  DumpReg = reg_onehot;
                  LoadAcc = (state == LATCH);
               end
               OP_A2R: begin
                  DumpAcc = 1'b1;
                  LoadReg = (state == LATCH) ? reg_onehot : '0;
               end
               OP_ALU: begin
                  DumpReg = reg_onehot;
                  alu_op  = alu_q;
                  LoadAcc = (state == LATCH);
                  alu_sel = (state == LATCH);
               end
               default: ;
            endcase
         end
         DONE: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_acc_xfer_ctrl.sv
// Scoreboard bench for acc_xfer_ctrl: per-cycle expected outputs are queued at command
// acceptance and popped each cycle; a second instance with NREG=3 covers the error path.
module tb_acc_xfer_ctrl;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_R2A = 2'b01;
   localparam logic [1:0] OP_A2R = 2'b10;
   localparam logic [1:0] OP_ALU = 2'b11;

   typedef struct packed {
      logic       ready;
      logic       load_acc;
      logic       dump_acc;
      logic [3:0] load_reg;
      logic [3:0] dump_reg;
      logic       alu_sel;
      logic [2:0] alu_op;
      logic       done;
      logic       err;
   } out_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_valid3;
   logic [1:0] cmd_op;
   logic [1:0] cmd_reg;
   logic [2:0] cmd_alu;

   logic       cmd_ready, load_acc, dump_acc, alu_sel, done, err;
   logic [3:0] load_reg, dump_reg;
   logic [2:0] alu_op;

   logic       cmd_ready3, load_acc3, dump_acc3, alu_sel3, done3, err3;
   logic [2:0] load_reg3, dump_reg3;
   logic [2:0] alu_op3;

   int   tests  = 0;
   int   failed = 0;
   out_t q[$];
   out_t q3[$];

   always #5 clk = ~clk;

   acc_xfer_ctrl dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_alu(cmd_alu),
      .LoadAcc(load_acc), .DumpAcc(dump_acc), .LoadReg(load_reg), .DumpReg(dump_reg),
      .alu_sel(alu_sel), .alu_op(alu_op), .done(done), .err(err)
   );

   acc_xfer_ctrl #(.NREG(3), .REG_W(2), .ALU_OP_W(3)) dut3 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_alu(cmd_alu),
      .LoadAcc(load_acc3), .DumpAcc(dump_acc3), .LoadReg(load_reg3), .DumpReg(dump_reg3),
      .alu_sel(alu_sel3), .alu_op(alu_op3), .done(done3), .err(err3)
   );

   function automatic out_t idle_out();
      out_t o;
      o = '0;
      o.ready = 1'b1;
      return o;
   endfunction

   function automatic out_t sample_main();
      out_t o;
      o.ready = cmd_ready;   o.load_acc = load_acc; o.dump_acc = dump_acc;
      o.load_reg = load_reg; o.dump_reg = dump_reg; o.alu_sel = alu_sel;
      o.alu_op = alu_op;     o.done = done;         o.err = err;
      return o;
   endfunction

   function automatic out_t sample_3();
      out_t o;
      o.ready = cmd_ready3;          o.load_acc = load_acc3;        o.dump_acc = dump_acc3;
      o.load_reg = {1'b0, load_reg3}; o.dump_reg = {1'b0, dump_reg3}; o.alu_sel = alu_sel3;
      o.alu_op = alu_op3;            o.done = done3;                o.err = err3;
      return o;
   endfunction

   function automatic out_t pop_main();
      if (q.size() > 0) return q.pop_front();
      return idle_out();
   endfunction

   function automatic out_t pop_3();
      if (q3.size() > 0) return q3.pop_front();
      return idle_out();
   endfunction

   // Expected outputs for the cycles after an accept edge, derived from the command alone.
   task automatic push_exp(input bit to3, input int nreg, input logic [1:0] op,
                           input logic [1:0] r, input logic [2:0] a);
      out_t c1, c2, c3;
      bit   bad;
      logic [3:0] onehot;
      bad    = (op != OP_NOP) && (int'(r) >= nreg);
      onehot = 4'b0001 << r;
      c3 = '0;
      c3.done = 1'b1;
      c3.err  = bad;
      if (op == OP_NOP || bad) begin
         if (to3) q3.push_back(c3); else q.push_back(c3);
      end else begin
         c1 = '0;
         if (op == OP_A2R) c1.dump_acc = 1'b1; else c1.dump_reg = onehot;
         if (op == OP_ALU) c1.alu_op = a;
         c2 = c1;
         if (op == OP_A2R) c2.load_reg = onehot; else c2.load_acc = 1'b1;
         if (op == OP_ALU) c2.alu_sel = 1'b1;
         if (to3) begin
            q3.push_back(c1); q3.push_back(c2); q3.push_back(c3);
         end else begin
            q.push_back(c1); q.push_back(c2); q.push_back(c3);
         end
      end
   endtask

   task automatic test_reset();
      out_t o;
      reset = 1'b0; cmd_valid = 1'b1; cmd_valid3 = 1'b0;
      cmd_op = OP_R2A; cmd_reg = 2'd2; cmd_alu = 3'd4;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         o = sample_main();
         tests++;
         if (o !== idle_out()) begin
            failed++;
            $display("[TB] FAIL reset cycle %0d: got %h, expected %h", c, o, idle_out());
         end
         if (c == 1) begin
            reset = 1'b1;
            cmd_valid = 1'b0;
         end
      end
   endtask

   task automatic test_r2a();
      out_t e, o;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         e = pop_main(); o = sample_main();
         tests++;
         if (o !== e) begin
            failed++;
            $display("[TB] FAIL r2a cycle %0d: got %h, expected %h", c, o, e);
         end
         cmd_valid = (c == 0); cmd_op = OP_R2A; cmd_reg = 2'd2; cmd_alu = 3'd6;
         if (cmd_valid && e.ready) push_exp(1'b0, 4, cmd_op, cmd_reg, cmd_alu);
      end
   endtask

   task automatic test_back_to_back();
      out_t e, o;
      int   phase = 0;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         e = pop_main(); o = sample_main();
         tests++;
         if (o !== e) begin
            failed++;
            $display("[TB] FAIL back_to_back cycle %0d: got %h, expected %h", c, o, e);
         end
         cmd_valid = (phase < 2);
         if (phase == 0) begin
            cmd_op = OP_A2R; cmd_reg = 2'd3; cmd_alu = 3'd2;
         end else begin
            cmd_op = OP_ALU; cmd_reg = 2'd1; cmd_alu = 3'd5;
         end
         if (cmd_valid && e.ready) begin
            push_exp(1'b0, 4, cmd_op, cmd_reg, cmd_alu);
            phase++;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_nop_err();
      out_t e, o;
      int   phase = 0;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         e = pop_3(); o = sample_3();
         tests++;
         if (o !== e) begin
            failed++;
            $display("[TB] FAIL nop_err cycle %0d: got %h, expected %h", c, o, e);
         end
         cmd_valid3 = (phase < 2);
         if (phase == 0) begin
            cmd_op = OP_NOP; cmd_reg = 2'd3; cmd_alu = 3'd7;
         end else begin
            cmd_op = OP_R2A; cmd_reg = 2'd3; cmd_alu = 3'd0;
         end
         if (cmd_valid3 && e.ready) begin
            push_exp(1'b1, 3, cmd_op, cmd_reg, cmd_alu);
            phase++;
         end
      end
      cmd_valid3 = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_t e, o;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         e = pop_main(); o = sample_main();
         tests++;
         if (o !== e) begin
            failed++;
            $display("[TB] FAIL reset_mid cycle %0d: got %h, expected %h", c, o, e);
         end
         cmd_valid = (c == 0); cmd_op = OP_R2A; cmd_reg = 2'd1; cmd_alu = 3'd0;
         if (cmd_valid && e.ready) push_exp(1'b0, 4, cmd_op, cmd_reg, cmd_alu);
      end
      #2 reset = 1'b0;
      #1 o = sample_main();
      tests++;
      if (o !== idle_out()) begin
         failed++;
         $display("[TB] FAIL reset_mid async drop: got %h, expected %h", o, idle_out());
      end
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         o = sample_main();
         tests++;
         if (o !== idle_out()) begin
            failed++;
            $display("[TB] FAIL reset_mid after release %0d: got %h, expected %h", c, o, idle_out());
         end
      end
   endtask

   task automatic test_random();
      out_t e, o;
      int   issued = 0, accepted = 0, done_seen = 0, cycles = 0;
      bit   pending = 0;
      bit   finished = 0;
      while (!finished && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         e = pop_main(); o = sample_main();
         tests++;
         if (o !== e) begin
            failed++;
            $display("[TB] FAIL random cycle %0d: got %h, expected %h", cycles, o, e);
         end
         tests++;
         if ((int'(o.dump_acc) + $countones(o.dump_reg)) > 1 || (o.load_acc && |o.load_reg) ||
             (o.load_acc && !(|o.dump_reg)) || (|o.load_reg && !o.dump_acc) ||
             !$onehot0(o.load_reg) || !$onehot0(o.dump_reg)) begin
            failed++;
            $display("[TB] FAIL random invariant cycle %0d: got %h, expected exclusive strobes", cycles, o);
         end
         if (o.done) done_seen++;
         if (!pending) begin
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_reg = 2'($urandom_range(0, 3));
            cmd_alu = 3'($urandom_range(0, 7));
            if (issued < 500 && $urandom_range(0, 3) != 0) begin
               cmd_valid = 1'b1;
               pending   = 1'b1;
               issued++;
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (pending && e.ready) begin
            push_exp(1'b0, 4, cmd_op, cmd_reg, cmd_alu);
            accepted++;
            pending = 1'b0;
         end
         finished = (issued == 500) && !pending && (q.size() == 0) && !cmd_valid;
      end
      cmd_valid = 1'b0;
      tests++;
      if (!finished) begin
         failed++;
         $display("[TB] FAIL random timeout: got %0d accepted, expected 500", accepted);
      end
      @(negedge clk);
      tests++;
      if (done_seen != accepted || accepted != 500) begin
         failed++;
         $display("[TB] FAIL random done_count: got %0d done for %0d accepted, expected 500", done_seen, accepted);
      end
   endtask

   initial begin
      test_reset();
      test_r2a();
      test_back_to_back();
      test_nop_err();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
